// File: rtl/vga_blank_cmd_scheduler.sv
// vga_blank_cmd_scheduler: FIFO-buffers host draw commands and releases them
// to the draw engine only while the raster is outside the visible picture.
// Ports: clk, rst (async, active-high); x/y/active raster position from the
// timing generator; cmd_valid/cmd_ready/cmd_data host side; eng_valid/
// eng_ready/eng_data/eng_done engine side; fifo_level, frame_cmds, sticky
// overrun with overrun_clr.
// Optional macro VGA_SCHED_HBLANK_EN: also issue "short" commands
// (cmd_data[CMD_WIDTH-1]==1) during horizontal blanking of visible lines.
module vga_blank_cmd_scheduler #(
    parameter int CMD_WIDTH      = 24,
    parameter int FIFO_DEPTH     = 8,
    parameter int V_VIS_START    = 35,
    parameter int V_VIS_END      = 515,
    parameter int GUARD_LINES    = 2,
    parameter int MAX_CMDS_FRAME = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [9:0]                        x,
    input  logic [9:0]                        y,
    input  logic                              active,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [CMD_WIDTH-1:0]              cmd_data,
    output logic                              eng_valid,
    input  logic                              eng_ready,
    output logic [CMD_WIDTH-1:0]              eng_data,
    input  logic                              eng_done,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic [7:0]                        frame_cmds,
    output logic                              overrun,
    input  logic                              overrun_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [9:0] Y_OPEN_END = 10'(V_VIS_START - GUARD_LINES);
    localparam logic [9:0] Y_VIS_BEG  = 10'(V_VIS_START);
    localparam logic [9:0] Y_VIS_END  = 10'(V_VIS_END);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    logic [CMD_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic [1:0]           state_q, state_d;
    logic                 window_q, window_d;
    logic                 hwin_q, hwin_d;
    logic [7:0]           frame_cmds_q, frame_cmds_d;
    logic                 overrun_q, overrun_d;

    logic full, empty, push, pop;
    logic frame_start, cap_ok, may_issue;

    assign full      = (level_q == LW'(FIFO_DEPTH));
    assign empty     = (level_q == '0);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign eng_valid = (state_q == S_ISSUE);
    assign eng_data  = mem_q[rd_ptr_q];
    assign pop       = eng_valid && eng_ready;

    assign fifo_level = level_q;
    assign frame_cmds = frame_cmds_q;
    assign overrun    = overrun_q;

    assign frame_start = (x == 10'd0) && (y == 10'd0);
    assign cap_ok = (MAX_CMDS_FRAME == 0) ||
                    ({24'd0, frame_cmds_q} < MAX_CMDS_FRAME);

    // Window flags are registered, so decisions lag the raster by one cycle.
    always_comb begin
        window_d = (y >= Y_VIS_END) || (y < Y_OPEN_END);
        hwin_d   = !active && (y >= Y_VIS_BEG) && (y < Y_VIS_END);
    end

`ifdef VGA_SCHED_HBLANK_EN
    // A long head command blocks the queue until vertical blanking.
    assign may_issue = (window_q || (hwin_q && eng_data[CMD_WIDTH-1]))
                       && !empty && cap_ok;
`else
    assign may_issue = window_q && !empty && cap_ok;
`endif

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) level_d = level_q + LW'(1);
        if (pop && !push) level_d = level_q - LW'(1);
    end

    // Frame start clears the count; a handshake on that cycle counts as 1.
    always_comb begin
        frame_cmds_d = frame_start ? 8'd0 : frame_cmds_q;
        if (pop && frame_cmds_d != 8'hFF) frame_cmds_d = frame_cmds_d + 8'd1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (may_issue) state_d = S_ISSUE;
            S_ISSUE: if (eng_ready) state_d = eng_done ? S_IDLE : S_BUSY;
            S_BUSY:  if (eng_done)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Set has priority over clear.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr) overrun_d = 1'b0;
        if (active && state_q != S_IDLE) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            state_q      <= S_IDLE;
            window_q     <= 1'b0;
            hwin_q       <= 1'b0;
            frame_cmds_q <= 8'd0;
            overrun_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            state_q      <= state_d;
            window_q     <= window_d;
            hwin_q       <= hwin_d;
            frame_cmds_q <= frame_cmds_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule
